fpu_stream_arb_mux: RTL and testbench

Parametrised, registered N-input stream multiplexer with valid/ready handshakes, used in the FPU8087 datapath to merge operand, tag and status streams from several producers into one consumer. Selection is round-robin or fixed-priority (parameter), with a runtime force-select override that reproduces plain select-driven muxing. One output register stage gives 1-cycle latency at full throughput.

---
 rtl/fpu_stream_arb_mux_if.sv | 28 ++
 rtl/fpu_stream_arb_mux.sv | 111 +++++++++++
 tb/tb_fpu_stream_arb_mux.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fpu_stream_arb_mux_if.sv
// Handshake bundle for the N-input stream arbiter/mux: producer channels, force-select override and the single output stream.
// slave = the mux itself; master = the producers and consumer driving it.
interface fpu_stream_arb_mux_if #(
    parameter int WIDTH  = 3,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic                    force_en;
    logic [SEL_W-1:0]        force_sel;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  in_data, in_valid, force_en, force_sel, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output in_data, in_valid, force_en, force_sel, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/fpu_stream_arb_mux.sv
// Registered N-input stream mux, round-robin or fixed-priority with force-select; 1-cycle latency, 1 beat/cycle.
// A stalled output (valid && !ready) holds data, sel and pointer and drops every in_ready.
module fpu_stream_arb_mux #(
    parameter int WIDTH  = 3,
    parameter int NUM_IN = 4,
    parameter int RR     = 1
) (
    input logic                 clk,
    input logic                 reset_n,
    fpu_stream_arb_mux_if.slave bus
);
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;

    logic              load;
    logic [NUM_IN-1:0] elig;
    logic [NUM_IN-1:0] gnt;
    logic              gnt_any;
    logic [SEL_W-1:0]  gnt_idx;
    logic              hi_any;
    logic [SEL_W-1:0]  hi_idx;
    logic              lo_any;
    logic [SEL_W-1:0]  lo_idx;
    logic [WIDTH-1:0]  mux_data;

    assign load = !out_valid_q || bus.out_ready;

    // Out-of-range force_sel matches no channel, so the eligible set is empty.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (bus.force_en) begin
                elig[i] = bus.in_valid[i] && (bus.force_sel == SEL_W'(i));
            end else begin
                elig[i] = bus.in_valid[i];
            end
        end
    end

    // Descending scans leave the lowest match; hi_* covers indices at/after ptr, lo_* wraps to 0.
    always_comb begin
        hi_any = 1'b0;
        hi_idx = '0;
        lo_any = 1'b0;
        lo_idx = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_any = 1'b1;
                lo_idx = SEL_W'(i);
                if (SEL_W'(i) >= ptr_q) begin
                    hi_any = 1'b1;
                    hi_idx = SEL_W'(i);
                end
            end
        end
        gnt_any = lo_any;
        gnt_idx = (RR != 0 && hi_any) ? hi_idx : lo_idx;
    end

    always_comb begin
        gnt      = '0;
        mux_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt_any && gnt_idx == SEL_W'(i)) begin
                gnt[i]   = 1'b1;
                mux_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.in_ready = gnt & {NUM_IN{load && reset_n}};

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = gnt_any;
            if (gnt_any) begin
                out_data_d = mux_data;
                out_sel_d  = gnt_idx;
                if (RR != 0) begin
                    ptr_d = (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_fpu_stream_arb_mux.sv
// Directed bench for fpu_stream_arb_mux: round-robin N=4, fixed-priority N=4 and round-robin N=3 instances.
module tb_fpu_stream_arb_mux;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fpu_stream_arb_mux_if #(.WIDTH(3), .NUM_IN(4)) ifa ();
    fpu_stream_arb_mux_if #(.WIDTH(3), .NUM_IN(4)) ifb ();
    fpu_stream_arb_mux_if #(.WIDTH(3), .NUM_IN(3)) ifc ();

    fpu_stream_arb_mux #(.WIDTH(3), .NUM_IN(4), .RR(1)) dut_rr  (.clk(clk), .reset_n(reset_n), .bus(ifa));
    fpu_stream_arb_mux #(.WIDTH(3), .NUM_IN(4), .RR(0)) dut_fp  (.clk(clk), .reset_n(reset_n), .bus(ifb));
    fpu_stream_arb_mux #(.WIDTH(3), .NUM_IN(3), .RR(1)) dut_n3  (.clk(clk), .reset_n(reset_n), .bus(ifc));

    task automatic do_reset();
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic test_reset();
        ifa.in_valid = 4'b1111; ifa.out_ready = 1'b1; ifa.force_en = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", ifa.out_valid); end
        checks++; if (ifa.out_data !== 3'd0) begin failures++; $display("FAIL rst_data got=%0h exp=0", ifa.out_data); end
        checks++; if (ifa.out_sel !== 2'd0) begin failures++; $display("FAIL rst_sel got=%0h exp=0", ifa.out_sel); end
        checks++; if (ifa.in_ready !== 4'b0000) begin failures++; $display("FAIL rst_in_ready got=%0h exp=0", ifa.in_ready); end
        @(negedge clk) reset_n = 1'b1;
        #1;
        checks++; if (ifa.in_ready !== 4'b0001) begin failures++; $display("FAIL rel_in_ready got=%0h exp=1", ifa.in_ready); end
        @(posedge clk); #1;
        checks++; if (ifa.out_valid !== 1'b1 || ifa.out_sel !== 2'd0 || ifa.out_data !== 3'd1) begin
            failures++; $display("FAIL rel_first v=%0h s=%0h d=%0h exp v=1 s=0 d=1", ifa.out_valid, ifa.out_sel, ifa.out_data); end
        @(posedge clk); #1;
        checks++; if (ifa.out_sel !== 2'd1) begin failures++; $display("FAIL rel_second_sel got=%0h exp=1", ifa.out_sel); end
        reset_n = 1'b0;
        #1;
        checks++; if (ifa.out_valid !== 1'b0 || ifa.out_data !== 3'd0 || ifa.out_sel !== 2'd0) begin
            failures++; $display("FAIL midrst_out v=%0h s=%0h d=%0h exp all 0", ifa.out_valid, ifa.out_sel, ifa.out_data); end
        checks++; if (ifa.in_ready !== 4'b0000) begin failures++; $display("FAIL midrst_in_ready got=%0h exp=0", ifa.in_ready); end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (ifa.out_valid !== 1'b1 || ifa.out_sel !== 2'd0 || ifa.out_data !== 3'd1) begin
            failures++; $display("FAIL midrst_regrant v=%0h s=%0h d=%0h exp v=1 s=0 d=1", ifa.out_valid, ifa.out_sel, ifa.out_data); end
    endtask

    task automatic test_rr_fairness();
        logic [1:0] es;
        logic [2:0] ed;
        logic [3:0] er;
        do_reset();
        ifa.in_valid = 4'b1111; ifa.out_ready = 1'b1; ifa.force_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            es = 2'(k % 4);
            ed = 3'((k % 4) + 1);
            er = 4'(1 << ((k + 1) % 4));
            checks++; if (ifa.out_valid !== 1'b1 || ifa.out_sel !== es || ifa.out_data !== ed) begin
                failures++; $display("FAIL rr_beat%0d v=%0h s=%0h d=%0h exp v=1 s=%0h d=%0h", k, ifa.out_valid, ifa.out_sel, ifa.out_data, es, ed); end
            checks++; if (ifa.in_ready !== er) begin
                failures++; $display("FAIL rr_ready%0d got=%0h exp=%0h", k, ifa.in_ready, er); end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        ifb.in_valid = 4'b1010; ifb.out_ready = 1'b1; ifb.force_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++; if (ifb.out_sel !== 2'd1 || ifb.out_data !== 3'd2 || ifb.in_ready !== 4'b0010) begin
                failures++; $display("FAIL fp_ch1_%0d s=%0h d=%0h r=%0h exp s=1 d=2 r=2", k, ifb.out_sel, ifb.out_data, ifb.in_ready); end
        end
        ifb.in_valid = 4'b1000;
        #1;
        checks++; if (ifb.in_ready !== 4'b1000) begin failures++; $display("FAIL fp_ready_ch3 got=%0h exp=8", ifb.in_ready); end
        @(posedge clk); #1;
        checks++; if (ifb.out_valid !== 1'b1 || ifb.out_sel !== 2'd3 || ifb.out_data !== 3'd4) begin
            failures++; $display("FAIL fp_ch3 v=%0h s=%0h d=%0h exp v=1 s=3 d=4", ifb.out_valid, ifb.out_sel, ifb.out_data); end
    endtask

    task automatic test_backpressure();
        do_reset();
        ifa.in_valid = 4'b1111; ifa.out_ready = 1'b1; ifa.force_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ifa.out_sel !== 2'd2) begin failures++; $display("FAIL bp_pre_sel got=%0h exp=2", ifa.out_sel); end
        ifa.out_ready = 1'b0;
        ifa.force_en = 1'b1; ifa.force_sel = 2'd0;
        #1;
        checks++; if (ifa.in_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready_now got=%0h exp=0", ifa.in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++; if (ifa.out_valid !== 1'b1 || ifa.out_sel !== 2'd2 || ifa.out_data !== 3'd3 || ifa.in_ready !== 4'b0000) begin
                failures++; $display("FAIL bp_hold%0d v=%0h s=%0h d=%0h r=%0h exp v=1 s=2 d=3 r=0", k, ifa.out_valid, ifa.out_sel, ifa.out_data, ifa.in_ready); end
        end
        ifa.force_en = 1'b0;
        ifa.out_ready = 1'b1;
        #1;
        checks++; if (ifa.in_ready !== 4'b1000) begin failures++; $display("FAIL bp_release_ready got=%0h exp=8", ifa.in_ready); end
        @(posedge clk); #1;
        checks++; if (ifa.out_sel !== 2'd3 || ifa.out_data !== 3'd4) begin
            failures++; $display("FAIL bp_release s=%0h d=%0h exp s=3 d=4", ifa.out_sel, ifa.out_data); end
    endtask

    task automatic test_force();
        do_reset();
        ifa.in_valid = 4'b1111; ifa.out_ready = 1'b1; ifa.force_en = 1'b1; ifa.force_sel = 2'd2;
        #1;
        checks++; if (ifa.in_ready !== 4'b0100) begin failures++; $display("FAIL force_ready_pre got=%0h exp=4", ifa.in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++; if (ifa.out_valid !== 1'b1 || ifa.out_sel !== 2'd2 || ifa.out_data !== 3'd3 || ifa.in_ready !== 4'b0100) begin
                failures++; $display("FAIL force_ch2_%0d v=%0h s=%0h d=%0h r=%0h exp v=1 s=2 d=3 r=4", k, ifa.out_valid, ifa.out_sel, ifa.out_data, ifa.in_ready); end
        end
        ifa.force_en = 1'b0;
        #1;
        checks++; if (ifa.in_ready !== 4'b1000) begin failures++; $display("FAIL force_ptr_adv got=%0h exp=8", ifa.in_ready); end
        @(posedge clk); #1;
        checks++; if (ifa.out_sel !== 2'd3) begin failures++; $display("FAIL force_after_sel got=%0h exp=3", ifa.out_sel); end

        do_reset();
        ifc.in_valid = 3'b111; ifc.out_ready = 1'b1; ifc.force_en = 1'b1; ifc.force_sel = 2'd1;
        @(posedge clk); #1;
        checks++; if (ifc.out_valid !== 1'b1 || ifc.out_sel !== 2'd1 || ifc.out_data !== 3'd2) begin
            failures++; $display("FAIL force_n3_ch1 v=%0h s=%0h d=%0h exp v=1 s=1 d=2", ifc.out_valid, ifc.out_sel, ifc.out_data); end
        ifc.force_sel = 2'd3;
        #1;
        checks++; if (ifc.in_ready !== 3'b000) begin failures++; $display("FAIL force_oor_ready got=%0h exp=0", ifc.in_ready); end
        @(posedge clk); #1;
        checks++; if (ifc.out_valid !== 1'b0 || ifc.out_sel !== 2'd1 || ifc.out_data !== 3'd2) begin
            failures++; $display("FAIL force_oor_drain v=%0h s=%0h d=%0h exp v=0 s=1 d=2", ifc.out_valid, ifc.out_sel, ifc.out_data); end
        ifc.force_en = 1'b0;
    endtask

    task automatic test_non_pow2();
        logic [1:0] es;
        logic [2:0] ed;
        do_reset();
        ifc.in_valid = 3'b111; ifc.out_ready = 1'b1; ifc.force_en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            es = 2'(k % 3);
            ed = 3'((k % 3) + 1);
            checks++; if (ifc.out_valid !== 1'b1 || ifc.out_sel !== es || ifc.out_data !== ed) begin
                failures++; $display("FAIL n3_beat%0d v=%0h s=%0h d=%0h exp v=1 s=%0h d=%0h", k, ifc.out_valid, ifc.out_sel, ifc.out_data, es, ed); end
        end
    endtask

    initial begin
        ifa.in_data = {3'd4, 3'd3, 3'd2, 3'd1}; ifa.in_valid = '0; ifa.force_en = 1'b0; ifa.force_sel = '0; ifa.out_ready = 1'b0;
        ifb.in_data = {3'd4, 3'd3, 3'd2, 3'd1}; ifb.in_valid = '0; ifb.force_en = 1'b0; ifb.force_sel = '0; ifb.out_ready = 1'b0;
        ifc.in_data = {3'd3, 3'd2, 3'd1};       ifc.in_valid = '0; ifc.force_en = 1'b0; ifc.force_sel = '0; ifc.out_ready = 1'b0;
        test_reset();
        test_rr_fairness();
        test_fixed_priority();
        test_backpressure();
        test_force();
        test_non_pow2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
